// File: rtl/max7219_pkg.sv
// Shared constants and types for the MAX7219 display sequencer.
// Optional runtime intensity port: MAX7219_INTENSITY_PORT_EN.
package max7219_pkg;

  localparam logic [7:0] REG_NOOP      = 8'h00;
  localparam logic [7:0] REG_DIGIT0    = 8'h01;
  localparam logic [7:0] REG_DECODE    = 8'h09;
  localparam logic [7:0] REG_INTENSITY = 8'h0A;
  localparam logic [7:0] REG_SCANLIM   = 8'h0B;
  localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
  localparam logic [7:0] REG_TEST      = 8'h0F;

  localparam int INIT_LEN           = 6;
  localparam int INIT_IDX_INTENSITY = 3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOAD,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_GAP
  } state_e;

  typedef enum logic [1:0] {
    WK_INIT,
    WK_INT,
    WK_ROW
  } word_kind_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [2:0] lowest_set(input logic [7:0] mask);
    lowest_set = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/max7219_busy_sync.sv
// Two-flop synchronizer bringing the transmitter busy flag into sys_clk.
module max7219_busy_sync (
  input  logic sys_clk,
  input  logic _rst,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], async_i};
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/max7219_display_ctrl.sv
// MAX7219 sequencer: power-up program, then dirty-row streaming to the transmitter.
// Define MAX7219_INTENSITY_PORT_EN to add the runtime intensity input.
module max7219_display_ctrl
  import max7219_pkg::*;
#(
  parameter logic [7:0]  DECODE_MODE = 8'h00,
  parameter logic [2:0]  SCAN_LIMIT  = 3'd7,
  parameter logic [3:0]  INTENSITY   = 4'h8,
  parameter logic [15:0] TIMEOUT     = 16'd4095
) (
  input  logic       sys_clk,
  input  logic       _rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
`ifdef MAX7219_INTENSITY_PORT_EN
  input  logic [3:0] intensity,
`endif
  output logic       ready,
  output logic       err,
  output logic       tx_str,
  output logic [7:0] tx_addr,
  output logic [7:0] tx_data,
  input  logic       tx_busy
);

  state_e     state_q, state_d;
  word_kind_e kind_q, kind_d;
  logic [2:0]  cmd_idx_q, cmd_idx_d;
  logic [2:0]  row_q, row_d;
  logic [7:0]  dirty_q, dirty_d;
  logic        tx_str_q, tx_str_d;
  logic [7:0]  tx_addr_q, tx_addr_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [15:0] timer_q, timer_d;
  logic        gap_q, gap_d;
  logic        retry_q, retry_d;
  logic [7:0]  fb_q [8];

  logic        busy_s;
  logic [3:0]  int_cur;
  logic        int_pending;
  logic [15:0] init_word;

  max7219_busy_sync u_busy_sync (
    .sys_clk (sys_clk),
    ._rst    (_rst),
    .async_i (tx_busy),
    .sync_o  (busy_s)
  );

`ifdef MAX7219_INTENSITY_PORT_EN
  logic [3:0] int_sent_q, int_sent_d;

  assign int_cur     = intensity;
  assign int_pending = (intensity != int_sent_q);

  // Remember the brightness actually latched into a word, from init or an update.
  always_comb begin
    int_sent_d = int_sent_q;
    if (state_q == ST_LOAD &&
        (kind_q == WK_INT ||
         (kind_q == WK_INIT && cmd_idx_q == 3'(INIT_IDX_INTENSITY)))) begin
      int_sent_d = intensity;
    end
  end

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) int_sent_q <= INTENSITY;
    else       int_sent_q <= int_sent_d;
  end
`else
  assign int_cur     = INTENSITY;
  assign int_pending = 1'b0;
`endif

  always_comb begin
    case (cmd_idx_q)
      3'd0:    init_word = {REG_SHUTDOWN,  8'h00};
      3'd1:    init_word = {REG_DECODE,    DECODE_MODE};
      3'd2:    init_word = {REG_SCANLIM,   {5'b0, SCAN_LIMIT}};
      3'd3:    init_word = {REG_INTENSITY, {4'b0, int_cur}};
      3'd4:    init_word = {REG_TEST,      8'h00};
      default: init_word = {REG_SHUTDOWN,  8'h01};
    endcase
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_fb
      always_ff @(posedge sys_clk or negedge _rst) begin
        if (!_rst)                              fb_q[gi] <= 8'h00;
        else if (wr_en && wr_row == 3'(gi))     fb_q[gi] <= wr_data;
      end
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    cmd_idx_d = cmd_idx_q;
    row_d     = row_q;
    dirty_d   = dirty_q;
    tx_str_d  = tx_str_q;
    tx_addr_d = tx_addr_q;
    tx_data_d = tx_data_q;
    ready_d   = ready_q;
    err_d     = err_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    retry_d   = retry_q;

    case (state_q)
      ST_INIT, ST_IDLE: begin
        if (cmd_idx_q < 3'(INIT_LEN)) begin
          kind_d  = WK_INIT;
          state_d = ST_LOAD;
        end else if (int_pending) begin
          kind_d  = WK_INT;
          state_d = ST_LOAD;
        end else if (|dirty_q) begin
          kind_d  = WK_ROW;
          row_d   = lowest_set(dirty_q);
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        case (kind_q)
          WK_INIT: {tx_addr_d, tx_data_d} = init_word;
          WK_INT:  {tx_addr_d, tx_data_d} = {REG_INTENSITY, {4'b0, int_cur}};
          default: begin
            tx_addr_d      = REG_DIGIT0 + {5'b0, row_q};
            tx_data_d      = fb_q[row_q];
            dirty_d[row_q] = 1'b0;
          end
        endcase
        tx_str_d = 1'b1;
        timer_d  = 16'd0;
        state_d  = ST_WAIT_HI;
      end

      ST_WAIT_HI: begin
        if (busy_s) begin
          state_d = ST_WAIT_LO;
        end else if (timer_q == TIMEOUT - 16'd1) begin
          err_d    = 1'b1;
          tx_str_d = 1'b0;
          retry_d  = 1'b1;
          state_d  = ST_GAP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end

      ST_WAIT_LO: begin
        if (!busy_s) begin
          tx_str_d = 1'b0;
          retry_d  = 1'b0;
          if (kind_q == WK_INIT) begin
            cmd_idx_d = cmd_idx_q + 3'd1;
            if (cmd_idx_q == 3'(INIT_LEN - 1)) ready_d = 1'b1;
          end
          state_d = ST_GAP;
        end
      end

      ST_GAP: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else begin
          gap_d = 1'b0;
          // A timed-out word goes out again exactly as latched.
          if (retry_q) begin
            tx_str_d = 1'b1;
            timer_d  = 16'd0;
            state_d  = ST_WAIT_HI;
          end else begin
            state_d = ready_q ? ST_IDLE : ST_INIT;
          end
        end
      end

      default: state_d = ST_INIT;
    endcase

    // Host writes land after the LOAD clear so a same-cycle write keeps the row dirty.
    if (wr_en) dirty_d[wr_row] = 1'b1;
  end

  always_ff @(posedge sys_clk or negedge _rst) begin
    if (!_rst) begin
      state_q   <= ST_INIT;
      kind_q    <= WK_INIT;
      cmd_idx_q <= 3'd0;
      row_q     <= 3'd0;
      dirty_q   <= 8'hFF;
      tx_str_q  <= 1'b0;
      tx_addr_q <= 8'h00;
      tx_data_q <= 8'h00;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      timer_q   <= 16'd0;
      gap_q     <= 1'b0;
      retry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      cmd_idx_q <= cmd_idx_d;
      row_q     <= row_d;
      dirty_q   <= dirty_d;
      tx_str_q  <= tx_str_d;
      tx_addr_q <= tx_addr_d;
      tx_data_q <= tx_data_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      retry_q   <= retry_d;
    end
  end

  assign ready   = ready_q;
  assign err     = err_q;
  assign tx_str  = tx_str_q;
  assign tx_addr = tx_addr_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_max7219_display_ctrl.sv
// Directed bench for max7219_display_ctrl with a behavioural transmitter model.
// Intensity-update step is built only with MAX7219_INTENSITY_PORT_EN.
module tb_max7219_display_ctrl;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic [2:0] wr_row  = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       ready, err, tx_str, tx_busy;
  logic [7:0] tx_addr, tx_data;
`ifdef MAX7219_INTENSITY_PORT_EN
  logic [3:0] intensity_v = 4'h8;
`endif

  int total = 0;
  int bad   = 0;

  // transmitter model state
  int         mst = 0, cnt = 0, word_cnt = 0, low_run = 0, gap_seen = 0, drop_lat = 0;
  int         stable_bad = 0, restart_bad = 0;
  logic [7:0] cap_addr = 8'h00, cap_data = 8'h00;
  logic       model_dead = 1'b0;
  int         seen = 0;

  always #5 sys_clk = ~sys_clk;

  max7219_display_ctrl dut (
    .sys_clk (sys_clk),
    ._rst    (rst_n),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
`ifdef MAX7219_INTENSITY_PORT_EN
    .intensity (intensity_v),
`endif
    .ready   (ready),
    .err     (err),
    .tx_str  (tx_str),
    .tx_addr (tx_addr),
    .tx_data (tx_data),
    .tx_busy (tx_busy)
  );

  // Behavioural transmitter: busy rises 30 cycles after str, lasts 1700 cycles.
  initial begin : model
    tx_busy = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      if (!rst_n) begin
        tx_busy = 1'b0; mst = 0; cnt = 0; low_run = 0;
      end else begin
        case (mst)
          0: begin
            if (tx_str && !model_dead) begin
              gap_seen = low_run; low_run = 0; cnt = 1; mst = 1;
            end else if (!tx_str) begin
              low_run++;
            end
          end
          1: begin
            cnt++;
            if (cnt == 30) begin
              tx_busy = 1'b1; cap_addr = tx_addr; cap_data = tx_data;
              word_cnt++; cnt = 0; mst = 2;
            end
          end
          2: begin
            if (!tx_str || tx_addr !== cap_addr || tx_data !== cap_data) stable_bad++;
            cnt++;
            if (cnt == 1700) begin tx_busy = 1'b0; cnt = 0; mst = 3; end
          end
          default: begin
            cnt++;
            if (!tx_str) begin
              drop_lat = cnt; low_run = 1; mst = 0;
            end else if (cnt >= 3) begin
              restart_bad++; mst = 0;
            end
          end
        endcase
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk); #2;
  endtask

  task automatic write_row(input int row, input int data);
    wr_en = 1'b1; wr_row = 3'(row); wr_data = 8'(data);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_rise(input string tag, input int exp_addr, input int exp_data);
    int got = 0;
    for (int i = 0; i < 6000 && got == 0; i++) begin
      tick();
      if (word_cnt != seen) got = 1;
    end
    seen = word_cnt;
    chk({tag, "_seen"}, got, 1);
    chk({tag, "_addr"}, int'(cap_addr), exp_addr);
    chk({tag, "_data"}, int'(cap_data), exp_data);
  endtask

  task automatic wait_done(input string tag);
    int got = 0;
    for (int i = 0; i < 2000 && got == 0; i++) begin
      tick();
      if (mst == 0 && !tx_busy) got = 1;
    end
    chk({tag, "_done"}, got, 1);
    chk({tag, "_droplat_le3"}, int'(drop_lat <= 3), 1);
  endtask

  task automatic wait_word(input string tag, input int exp_addr, input int exp_data);
    wait_rise(tag, exp_addr, exp_data);
    wait_done(tag);
  endtask

  task automatic quiet(input string tag, input int n);
    int s;
    s = word_cnt;
    repeat (n) tick();
    chk({tag, "_extra_words"}, word_cnt - s, 0);
    chk({tag, "_str_idle"}, int'(tx_str), 0);
  endtask

  initial begin : stim
    int got;
    // 1: reset values, init program, initial row flush
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_str",   int'(tx_str),  0);
    chk("rst_addr",  int'(tx_addr), 0);
    chk("rst_data",  int'(tx_data), 0);
    chk("rst_ready", int'(ready),   0);
    chk("rst_err",   int'(err),     0);
    rst_n = 1'b1;
    wait_word("init0", 'h0C, 'h00);
    wait_word("init1", 'h09, 'h00);
    wait_word("init2", 'h0B, 'h07);
    wait_word("init3", 'h0A, 'h08);
    wait_word("init4", 'h0F, 'h00);
    wait_rise("init5", 'h0C, 'h01);
    chk("ready_before_last", int'(ready), 0);
    wait_done("init5");
    chk("ready_after_init", int'(ready), 1);
    for (int r = 0; r < 8; r++) wait_word($sformatf("flush_row%0d", r), r + 1, 0);
    quiet("t1", 1000);

    // 2: single row write
    write_row(5, 'hA5);
    wait_word("t2_row5", 'h06, 'hA5);
    quiet("t2", 1000);

    // 3: rewrite of a row while its word is in flight
    write_row(2, 'h11);
    wait_rise("t3_first", 'h03, 'h11);
    repeat (10) tick();
    write_row(2, 'h22);
    wait_done("t3_first");
    wait_word("t3_resend", 'h03, 'h22);
    quiet("t3", 1000);

    // 4: three rows queued behind a transfer go out lowest row first
    write_row(5, 'h55);
    wait_rise("t4_lead", 'h06, 'h55);
    repeat (10) tick();
    write_row(7, 'h77);
    write_row(0, 'h3C);
    write_row(3, 'hC3);
    wait_done("t4_lead");
    wait_rise("t4_row0", 'h01, 'h3C);
    chk("t4_gap0", int'(gap_seen >= 2), 1);
    wait_done("t4_row0");
    wait_rise("t4_row3", 'h04, 'hC3);
    chk("t4_gap3", int'(gap_seen >= 2), 1);
    wait_done("t4_row3");
    wait_rise("t4_row7", 'h08, 'h77);
    chk("t4_gap7", int'(gap_seen >= 2), 1);
    wait_done("t4_row7");
    quiet("t4", 1000);

`ifdef MAX7219_INTENSITY_PORT_EN
    // 6: intensity update outranks pending rows
    write_row(4, 'h44);
    wait_rise("t6_lead", 'h05, 'h44);
    repeat (10) tick();
    write_row(1, 'h11);
    write_row(6, 'h66);
    intensity_v = 4'hF;
    wait_done("t6_lead");
    wait_word("t6_int", 'h0A, 'h0F);
    wait_word("t6_row1", 'h02, 'h11);
    wait_word("t6_row6", 'h07, 'h66);
    quiet("t6", 1000);
`endif

    chk("model_stable", stable_bad, 0);
    chk("model_restart", restart_bad, 0);

    // 5: transmitter never answers -> timeout, err, retry; reset clears err
    model_dead = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("t5_rst_err", int'(err), 0);
    rst_n = 1'b1;
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      tick();
      if (tx_str) got = 1;
    end
    chk("t5_str_seen", got, 1);
    chk("t5_addr", int'(tx_addr), 'h0C);
    chk("t5_data", int'(tx_data), 'h00);
    repeat (4000) tick();
    chk("t5_err_early", int'(err), 0);
    chk("t5_str_held", int'(tx_str), 1);
    got = 0;
    for (int i = 0; i < 300 && got == 0; i++) begin
      tick();
      if (err) got = 1;
    end
    chk("t5_err_set", got, 1);
    chk("t5_str_dropped", int'(tx_str), 0);
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (tx_str) got = 1;
    end
    chk("t5_retry_seen", got, 1);
    chk("t5_retry_addr", int'(tx_addr), 'h0C);
    chk("t5_retry_data", int'(tx_data), 'h00);
    chk("t5_err_sticky", int'(err), 1);
    rst_n = 1'b0;
    tick();
    chk("t5_err_cleared", int'(err), 0);
    chk("t5_str_cleared", int'(tx_str), 0);
    model_dead = 1'b0;
    seen = word_cnt;
    rst_n = 1'b1;
    wait_word("t5_reinit0", 'h0C, 'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
